seq_addsub_cc: RTL and testbench
================================

Name: seq_addsub_cc

Overview:
- Bit-serial-by-word multi-precision adder/subtractor for garbled-circuit netlists.
- Processes one W-bit chunk of an N = W*CC-bit operand pair per accepted cycle, least-significant chunk first, carrying the internal carry/borrow between chunks in a register.
- Generalises the fixed-width sequential adder:
  - parametrised width and chunk count
  - per-operation add/sub mode
  - valid/stall handshake
  - automatic carry initialisation at each operation boundary
  - flush
  - carry-out and signed-overflow flags

Parameters:
- W, 32, chunk width in bits (>=1).
- CC, 32, chunks per operation (>=2); operation width N = W*CC.
- IW, $clog2(CC), chunk-index width (derived, not overridden).

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, a/b/sub carry a chunk this cycle.
- flush, input, 1, abort current operation.
- sub, input, 1, mode: 0 = a+b, 1 = a-b; sampled only on chunk 0.
- a, input, W, operand A chunk.
- b, input, W, operand B chunk.
- c, output, W, result chunk (registered).
- out_valid, output, 1, c holds a valid chunk.
- out_first, output, 1, c is chunk 0 of an operation.
- out_last, output, 1, c is chunk CC-1; flags valid.
- carry_out, output, 1, final carry (sub: 1 = no borrow); updated only with out_last.
- overflow, output, 1, signed overflow of the N-bit result; updated only with out_last.
- busy, output, 1, operation in progress (chunk index != 0).
- chunk_idx, output, IW, index of next chunk expected.

Behaviour:
- Reset: when rst=1 at a clock edge, all outputs and state clear to 0 (c, out_valid, out_first, out_last, carry_out, overflow, busy, chunk_idx, carry reg, mode reg). rst overrides every other input.
- States:
  - IDLE: chunk_idx = 0.
  - RUN: 0 < chunk_idx < CC.
  - busy = (state == RUN).
- Accept: a chunk is accepted when in_valid=1 and flush=0.
- Effective operand: b_eff = sub_mode ? ~b : b.
- Chunk 0 (IDLE):
  - mode_reg <= sub.
  - carry_in = sub; the carry register is ignored.
  - IDLE -> RUN.
- Chunk k>0:
  - carry_in = carry register.
  - sub input ignored; mode_reg is used.
- Sum: {cout, s} = a + b_eff + carry_in, width W+1. The carry register takes cout; c takes s.
- Latency: one cycle. Chunk accepted at edge t appears on c with out_valid=1 after edge t.
- Output when nothing is accepted: out_valid, out_first and out_last drop to 0. c holds its last value.
- Stall: in_valid=0 holds chunk_idx, the carry register and mode_reg unchanged; any number of stall cycles is allowed.
- Chunk CC-1:
  - out_last=1.
  - carry_out <= cout.
  - overflow <= carry into bit W-1 XOR cout of the top chunk.
  - chunk_idx wraps to 0; RUN -> IDLE.
- Flags: carry_out and overflow persist until the next last chunk or reset.
- Back-to-back: chunk 0 of the next operation may be accepted in the cycle immediately after chunk CC-1, with no bubble.
- Flush:
  - chunk_idx <= 0; state -> IDLE.
  - out_valid/out_first/out_last <= 0.
  - Any chunk presented the same cycle is discarded (flush wins over in_valid).
  - carry_out/overflow are unchanged.
  - Flush in IDLE is a no-op apart from clearing out_valid.
- W=1: the overflow term degenerates to carry_in XOR cout of the top chunk.
- No combinational path from inputs to outputs.

Test Plan:
- Default parameters, W=32, CC=4 for the directed cases unless noted.
- Add with full carry ripple: rst 2 cycles; sub=0; a chunks all 0xFFFFFFFF, b chunk0=0x00000001, others 0, in_valid continuous -> c = 0x00000000 x4, out_first on the 1st output, out_last on the 4th, carry_out=1, overflow=0, 1-cycle latency.
- Subtract with borrow: sub=1, a all 0, b chunk0=1, others 0 -> c = 0xFFFFFFFF x4, carry_out=0, overflow=0.
- Signed overflow: sub=0, lower three chunks 0, top a=0x7FFFFFFF, b=0x00000001 -> top c=0x80000000, overflow=1, carry_out=0.
- Stall and mode latch:
  - Stimulus: same operands as the first case, in_valid=0 for 3 cycles between chunks 1 and 2, and sub toggled to 1 during chunks 1-3.
  - Response: identical c and flags to the first case; out_valid=0 during the gaps; busy=1 and chunk_idx=2 throughout the stall.
- Back-to-back operations: op A (sub, 5-3 in chunk0, rest 0), then op B (add, 5+3) starting the very next cycle -> A chunk0 c=0x00000002, carry_out=1; B chunk0 c=0x00000008, carry_out=0; 8 consecutive out_valid cycles.
- Flush and reset mid-operation:
  - flush after chunk 2 together with in_valid=1 -> that chunk is discarded and chunk_idx=0; the following clean op 1+1 gives chunk0 c=2.
  - Repeat the case with rst instead of flush -> all outputs 0 the next cycle, and the same clean result after it.

Source files
------------

// File: rtl/seq_addsub_cc.sv
// Word-serial multi-precision adder/subtractor: one W-bit chunk per accepted
// cycle, least-significant first, with the inter-chunk carry kept in a register.
module seq_addsub_cc #(
  parameter int W = 32,
  parameter int CC = 32,
  localparam int IW = $clog2(CC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          flush,
  input  logic          sub,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [W-1:0]  c,
  output logic          out_valid,
  output logic          out_first,
  output logic          out_last,
  output logic          carry_out,
  output logic          overflow,
  output logic          busy,
  output logic [IW-1:0] chunk_idx
);

  // Handshake: a chunk is taken on a rising edge when in_valid=1 and flush=0.
  // There is no backpressure; in_valid may stay low for any number of cycles.
  // Each accepted chunk yields exactly one out_valid=1 cycle, one cycle later.

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] idx_next;

  logic          carry_reg;
  logic          mode_reg;

  logic          accept;
  logic          is_first;
  logic          is_last;
  logic          mode_eff;
  logic          carry_in;
  logic [W-1:0]  b_eff;
  logic [W:0]    sum;
  logic          msb_carry_in;
  logic          ovf;

  assign accept   = in_valid & ~flush;
  assign is_first = (state == IDLE);
  assign is_last  = (chunk_idx == IW'(CC - 1));

  // Chunk 0 takes mode and carry-in straight from sub; later chunks use the registers.
  assign mode_eff = is_first ? sub : mode_reg;
  assign carry_in = is_first ? sub : carry_reg;
  assign b_eff    = mode_eff ? ~b : b;
  assign sum      = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, carry_in};

  // Carry into the top bit recovered from the sum bit; reduces to carry_in when W=1.
  assign msb_carry_in = sum[W-1] ^ a[W-1] ^ b_eff[W-1];
  assign ovf          = msb_carry_in ^ sum[W];

  assign busy = (state == RUN);

  always_comb begin
    state_next = state;
    idx_next   = chunk_idx;
    if (flush) begin
      state_next = IDLE;
      idx_next   = '0;
    end else if (in_valid) begin
      if (is_last) begin
        state_next = IDLE;
        idx_next   = '0;
      end else begin
        state_next = RUN;
        idx_next   = chunk_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      chunk_idx <= '0;
      carry_reg <= 1'b0;
      mode_reg  <= 1'b0;
      c         <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      chunk_idx <= idx_next;
      out_valid <= accept;
      out_first <= accept & is_first;
      out_last  <= accept & is_last;
      if (accept) begin
        c         <= sum[W-1:0];
        carry_reg <= sum[W];
        if (is_first) begin
          mode_reg <= sub;
        end
        if (is_last) begin
          carry_out <= sum[W];
          overflow  <= ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_addsub_cc.sv
// Scoreboard bench for seq_addsub_cc: whole-operand arithmetic model, chunked
// expectations queued at issue time and popped by an output monitor.
module tb_seq_addsub_cc;

  localparam int W  = 32;
  localparam int CC = 4;
  localparam int N  = W * CC;
  localparam int IW = 2;

  typedef struct packed {
    logic [W-1:0] c;
    logic         first;
    logic         last;
    logic         co;
    logic         ov;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          flush;
  logic          sub;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  c;
  logic          out_valid;
  logic          out_first;
  logic          out_last;
  logic          carry_out;
  logic          overflow;
  logic          busy;
  logic [IW-1:0] chunk_idx;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   streak = 0;
  logic m_co = 1'b0;
  logic m_ov = 1'b0;

  seq_addsub_cc #(.W(W), .CC(CC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .sub(sub),
    .a(a), .b(b), .c(c), .out_valid(out_valid), .out_first(out_first),
    .out_last(out_last), .carry_out(carry_out), .overflow(overflow),
    .busy(busy), .chunk_idx(chunk_idx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: the whole N-bit operation in plain arithmetic.
  task automatic ref_op(input logic s, input logic [N-1:0] opa, input logic [N-1:0] opb,
                        output logic [N-1:0] r, output logic co, output logic ov);
    if (!s) begin
      {co, r} = {1'b0, opa} + {1'b0, opb};
      ov = (opa[N-1] == opb[N-1]) && (r[N-1] != opa[N-1]);
    end else begin
      r  = opa - opb;
      co = (opa >= opb);
      ov = (opa[N-1] != opb[N-1]) && (r[N-1] != opa[N-1]);
    end
  endtask

  function automatic logic [N-1:0] rand_operand();
    logic [N-1:0] v;
    v = '0;
    case ($urandom_range(0, 5))
      0: v = '1;
      1: v = '0;
      2: begin v = '1; v[N-1] = 1'b0; end
      3: begin v = '0; v[N-1] = 1'b1; end
      default: for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    endcase
    return v;
  endfunction

  // driver tasks
  task automatic cycle_in(input logic v, input logic f, input logic s,
                          input logic [W-1:0] av, input logic [W-1:0] bv);
    @(posedge clk);
    #1;
    in_valid = v;
    flush    = f;
    sub      = s;
    a        = av;
    b        = bv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_in(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic run_op(input logic s, input logic [N-1:0] opa, input logic [N-1:0] opb,
                        input int n, input int stall_at, input int stall_len, input logic toggle);
    logic [N-1:0] r;
    logic co, ov;
    exp_t e;
    ref_op(s, opa, opb, r, co, ov);
    for (int k = 0; k < n; k++) begin
      if (k == stall_at) begin
        for (int j = 0; j < stall_len; j++) begin
          cycle_in(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
          @(negedge clk);
          check("stall_idx", 64'(chunk_idx), 64'(k));
          check("stall_busy", 64'(busy), 64'(k != 0));
          if (j > 0) check("stall_valid", 64'(out_valid), 64'd0);
        end
      end
      cycle_in(1'b1, 1'b0, (k > 0 && toggle) ? ~s : s, opa[k*W +: W], opb[k*W +: W]);
      e.c     = r[k*W +: W];
      e.first = (k == 0);
      e.last  = (k == CC - 1);
      if (e.last) begin
        m_co = co;
        m_ov = ov;
      end
      e.co = m_co;
      e.ov = m_ov;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_c"}, 64'(c), 64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_first"}, 64'(out_first), 64'd0);
    check({tag, "_last"}, 64'(out_last), 64'd0);
    check({tag, "_cout"}, 64'(carry_out), 64'd0);
    check({tag, "_ovf"}, 64'(overflow), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_idx"}, 64'(chunk_idx), 64'd0);
  endtask

  task automatic do_flush();
    cycle_in(1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
    cycle_in(1'b0, 1'b0, 1'b0, $urandom, $urandom);
    @(negedge clk);
    check("flush_idx", 64'(chunk_idx), 64'd0);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_cout", 64'(carry_out), 64'(m_co));
    check("flush_ovf", 64'(overflow), 64'(m_ov));
  endtask

  task automatic do_reset();
    cycle_in(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
    rst = 1'b1;
    cycle_in(1'b0, 1'b0, 1'b0, $urandom, $urandom);
    rst = 1'b0;
    m_co = 1'b0;
    m_ov = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      exp_t e;
      streak++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("c", 64'(c), 64'(e.c));
        check("out_first", 64'(out_first), 64'(e.first));
        check("out_last", 64'(out_last), 64'(e.last));
        check("carry_out", 64'(carry_out), 64'(e.co));
        check("overflow", 64'(overflow), 64'(e.ov));
      end
    end else begin
      streak = 0;
    end
  end

  initial begin
    logic [N-1:0] ones, one, top_a, top_b, five, three;
    ones  = '1;
    one   = N'(1);
    top_a = '0; top_a[N-1 -: W] = 32'h7FFF_FFFF;
    top_b = '0; top_b[N-1 -: W] = 32'h0000_0001;
    five  = N'(5);
    three = N'(3);

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    run_op(1'b0, ones, one, CC, -1, 0, 1'b0);
    idle(1);
    run_op(1'b1, '0, one, CC, -1, 0, 1'b0);
    idle(1);
    run_op(1'b0, top_a, top_b, CC, -1, 0, 1'b0);
    idle(1);
    run_op(1'b0, ones, one, CC, 2, 3, 1'b1);
    idle(1);

    run_op(1'b1, five, three, CC, -1, 0, 1'b0);
    run_op(1'b0, five, three, CC, -1, 0, 1'b0);
    idle(1);
    @(negedge clk);
    #1 check("b2b_streak", 64'(streak), 64'd8);

    run_op(1'b0, rand_operand(), rand_operand(), 2, -1, 0, 1'b0);
    do_flush();
    run_op(1'b0, one, one, CC, -1, 0, 1'b0);
    idle(1);
    run_op(1'b0, rand_operand(), rand_operand(), 2, -1, 0, 1'b0);
    do_reset();
    run_op(1'b0, one, one, CC, -1, 0, 1'b0);
    idle(1);

    for (int t = 0; t < 60; t++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        run_op(1'($urandom_range(0, 1)), rand_operand(), rand_operand(),
               int'($urandom_range(1, CC - 1)), -1, 0, 1'b0);
        do_flush();
      end else if (kind == 1) begin
        run_op(1'($urandom_range(0, 1)), rand_operand(), rand_operand(),
               int'($urandom_range(1, CC - 1)), -1, 0, 1'b0);
        do_reset();
      end else begin
        run_op(1'($urandom_range(0, 1)), rand_operand(), rand_operand(), CC,
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, CC - 1)) : -1,
               int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
      end
    end

    idle(3);
    @(negedge clk);
    #1 check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
